// File: rtl/qk_score_engine_if.sv
// Handshake and data bundle for the Q*K^T score stage.
// Upstream drives Q/K/V in, downstream consumes A/V out.
interface qk_score_engine_if #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int TOKEN_DIM  = 4,
   parameter int TOKEN_NUM  = 8
);
   localparam int MW = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
   localparam int AW = OUT_WIDTH * TOKEN_NUM * TOKEN_NUM;

   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] Q_in;
   logic [MW-1:0] K_in;
   logic [MW-1:0] V_in;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] A_out;
   logic [MW-1:0] V_out;
   logic          busy;

   modport master (
      output in_valid, Q_in, K_in, V_in, out_ready,
      input  in_ready, out_valid, A_out, V_out, busy
   );

   modport slave (
      input  in_valid, Q_in, K_in, V_in, out_ready,
      output in_ready, out_valid, A_out, V_out, busy
   );
endinterface

// File: rtl/qk_score_engine.sv
// Multi-cycle Q*K^T score engine: one score row per clock.
// Optional build macro QK_CAUSAL_MASK_EN forces scores with j>i to min.
module qk_score_engine #(
   parameter int DATA_WIDTH  = 16,
   parameter int OUT_WIDTH   = 16,
   parameter int TOKEN_DIM   = 4,
   parameter int TOKEN_NUM   = 8,
   parameter int SCALE_SHIFT = 1
) (
   input logic               clk,
   input logic               rst_n,
   qk_score_engine_if.slave  bus
);
   localparam int MW    = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
   localparam int AW    = OUT_WIDTH * TOKEN_NUM * TOKEN_NUM;
   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(TOKEN_DIM);
   localparam int SAT_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
   localparam int CNT_W = $clog2(TOKEN_NUM);
   localparam int EXT_W = ACC_W - DATA_WIDTH;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOKEN_NUM - 1);

   localparam logic signed [SAT_W-1:0] MAX_S =
      {{(SAT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] MIN_S =
      {{(SAT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [MW-1:0]    q_q, q_d;
   logic [MW-1:0]    k_q, k_d;
   logic [MW-1:0]    v_q, v_d;
   logic [AW-1:0]    a_q, a_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [OUT_WIDTH-1:0] row_s [TOKEN_NUM];

   // Scaled, saturated score row for the current query row, one lane per key
   always_comb begin
      logic signed [DATA_WIDTH-1:0] qe;
      logic signed [DATA_WIDTH-1:0] ke;
      logic signed [ACC_W-1:0]      qx;
      logic signed [ACC_W-1:0]      kx;
      logic signed [ACC_W-1:0]      acc;
      logic signed [ACC_W-1:0]      sh;
      logic signed [SAT_W-1:0]      sx;
      int r;
      qe  = '0;
      ke  = '0;
      qx  = '0;
      kx  = '0;
      acc = '0;
      sh  = '0;
      sx  = '0;
      r   = int'(row_cnt_q);
      for (int j = 0; j < TOKEN_NUM; j++) begin
         row_s[j] = '0;
      end
      for (int j = 0; j < TOKEN_NUM; j++) begin
         acc = '0;
         for (int k = 0; k < TOKEN_DIM; k++) begin
            qe  = q_q[(r*TOKEN_DIM+k)*DATA_WIDTH +: DATA_WIDTH];
            ke  = k_q[(j*TOKEN_DIM+k)*DATA_WIDTH +: DATA_WIDTH];
            qx  = {{EXT_W{qe[DATA_WIDTH-1]}}, qe};
            kx  = {{EXT_W{ke[DATA_WIDTH-1]}}, ke};
            acc = acc + qx * kx;
         end
         sh = acc >>> SCALE_SHIFT;
         sx = {{(SAT_W-ACC_W){sh[ACC_W-1]}}, sh};
         if (sx > MAX_S) begin
            row_s[j] = MAX_O;
         end else if (sx < MIN_S) begin
            row_s[j] = MIN_O;
         end else begin
            row_s[j] = sx[OUT_WIDTH-1:0];
         end
`ifdef QK_CAUSAL_MASK_EN
         if (j > r) begin
            row_s[j] = MIN_O;
         end
`endif
      end
   end

   // Next-state logic: capture block, fill score rows, hold until accepted
   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      q_d         = q_q;
      k_d         = k_q;
      v_d         = v_q;
      a_d         = a_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               q_d        = bus.Q_in;
               k_d        = bus.K_in;
               v_d        = bus.V_in;
               row_cnt_d  = '0;
               state_d    = COMPUTE;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         COMPUTE: begin
            for (int j = 0; j < TOKEN_NUM; j++) begin
               a_d[(int'(row_cnt_q)*TOKEN_NUM+j)*OUT_WIDTH +: OUT_WIDTH] =
                  row_s[j];
            end
            row_cnt_d = row_cnt_q + 1'b1;
            if (row_cnt_q == LAST) begin
               row_cnt_d   = '0;
               state_d     = DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset discards any block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         q_q         <= '0;
         k_q         <= '0;
         v_q         <= '0;
         a_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         q_q         <= q_d;
         k_q         <= k_d;
         v_q         <= v_d;
         a_q         <= a_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.A_out     = a_q;
   assign bus.V_out     = v_q;
endmodule

// File: tb/tb_qk_score_engine.sv
// Directed bench for qk_score_engine with default parameters.
// Expected scores are hand-computed; the causal build is selected by macro.
module tb_qk_score_engine;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   qk_score_engine_if bus ();

   qk_score_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] fill(input logic [15:0] x);
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = x;
      return r;
   endfunction

   function automatic logic [511:0] ramp();
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'(i);
      return r;
   endfunction

   function automatic logic [511:0] first(input logic [15:0] x);
      logic [511:0] r;
      r = '0;
      r[15:0] = x;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [15:0] v00,
                          input logic [15:0] vrest);
      logic [15:0] e;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            e = (i == 0 && j == 0) ? v00 : vrest;
`ifdef QK_CAUSAL_MASK_EN
            if (j > i) e = 16'h8000;
`endif
            chk($sformatf("%s_A%0d%0d", tag, i, j),
                bus.A_out[(i*8+j)*16 +: 16], e);
         end
      end
   endtask

   task automatic send(input string tag, input logic [511:0] q,
                       input logic [511:0] k, input logic [511:0] v);
      @(negedge clk);
      bus.Q_in = q;
      bus.K_in = k;
      bus.V_in = v;
      bus.in_valid = 1'b1;
      chk({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.Q_in = '0;
      bus.K_in = '0;
      bus.V_in = '0;
      chk({tag, "_busy"}, bus.busy, 1'b1);
      chk({tag, "_in_ready_busy"}, bus.in_ready, 1'b0);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 512'(n), 512'(8));
      chk({tag, "_busy_done"}, bus.busy, 1'b0);
   endtask

   task automatic finish_out(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_out_valid_drop"}, bus.out_valid, 1'b0);
      chk({tag, "_in_ready_back"}, bus.in_ready, 1'b1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
      chk({tag, "_A_out"}, 512'(bus.A_out[511:0]), 512'(0));
      chk({tag, "_A_out_hi"}, 512'(bus.A_out[1023:512]), 512'(0));
      chk({tag, "_V_out"}, bus.V_out, 512'(0));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.Q_in = '0;
      bus.K_in = '0;
      bus.V_in = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      // Basic block: 4*(1*2)=8, >>>1 -> 4
      send("basic", fill(16'd1), fill(16'd2), ramp());
      wait_valid("basic");
      check_a("basic", 16'h0004, 16'h0004);
      chk("basic_V_out", bus.V_out, ramp());
      finish_out("basic");

      // Sign and floor: -3 >>> 1 -> -2
      send("sign", first(16'hFFFD), first(16'h0001), fill(16'h0000));
      wait_valid("sign");
      check_a("sign", 16'hFFFE, 16'h0000);
      finish_out("sign");

      // Positive saturation
      send("satp", fill(16'h7FFF), fill(16'h7FFF), fill(16'h1234));
      wait_valid("satp");
      check_a("satp", 16'h7FFF, 16'h7FFF);
      chk("satp_V_out", bus.V_out, fill(16'h1234));
      finish_out("satp");

      // Negative saturation
      send("satn", fill(16'h7FFF), fill(16'h8000), fill(16'hABCD));
      wait_valid("satn");
      check_a("satn", 16'h8000, 16'h8000);
      finish_out("satn");

      // Backpressure with a second block waiting: 4*3=12 >>> 1 -> 6
      bus.out_ready = 1'b0;
      send("bp", fill(16'd1), fill(16'd3), ramp());
      wait_valid("bp");
      bus.Q_in = fill(16'd1);
      bus.K_in = fill(16'd1);
      bus.V_in = fill(16'h55AA);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d_out_valid", c), bus.out_valid, 1'b1);
         chk($sformatf("bp_hold%0d_in_ready", c), bus.in_ready, 1'b0);
         chk($sformatf("bp_hold%0d_A53", c), bus.A_out[(5*8+3)*16 +: 16],
             16'h0006);
         chk($sformatf("bp_hold%0d_V_out", c), bus.V_out, ramp());
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", bus.out_valid, 1'b0);
      chk("bp_release_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp2_busy", bus.busy, 1'b1);
      chk("bp2_in_ready", bus.in_ready, 1'b0);
      wait_valid("bp2");
      check_a("bp2", 16'h0002, 16'h0002);
      chk("bp2_V_out", bus.V_out, fill(16'h55AA));
      finish_out("bp2");

      // Reset in the middle of COMPUTE, after rows 0..2 are written
      send("mid", fill(16'd2), fill(16'hFFFF), fill(16'h0F0F));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("midrst_quiet%0d", c), bus.out_valid, 1'b0);
      end

      // Fresh block after reset: 4*(2*-1)=-8 >>> 1 -> -4
      send("fresh", fill(16'd2), fill(16'hFFFF), fill(16'h0F0F));
      wait_valid("fresh");
      check_a("fresh", 16'hFFFC, 16'hFFFC);
      chk("fresh_V_out", bus.V_out, fill(16'h0F0F));
      finish_out("fresh");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
